// File: rtl/sub_serial_8_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DATA_W    : default operand/result width
//   state_e   : controller state encoding (IDLE/SHIFT/DONE)
//   cnt_width : width of the step counter for a given operand size
package sub_serial_8_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must hold 0..SIZE-1; guard keeps it at least one bit wide.
  function automatic int cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_8_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module sub_serial_8_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_serial_8.sv
// Bit-serial subtractor r = a - b, one bit per clock, LSB first.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled in IDLE only
//   a, b       : minuend / subtrahend, latched on the accepted start
//   busy       : high while shifting
//   done       : one-cycle completion pulse
//   r          : difference mod 2^SIZE (held until next completion)
//   bo, z, v   : borrow out, zero, signed overflow (held likewise)
module sub_serial_8
  import sub_serial_8_pkg::*;
#(
  parameter int SIZE = DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] r,
  output logic            bo,
  output logic            z,
  output logic            v
);

  localparam int CNT_W = cnt_width(SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_sh_q, a_sh_d;
  logic [SIZE-1:0]   b_sh_q, b_sh_d;
  logic [SIZE-1:0]   res_sh_q, res_sh_d;
  logic              borrow_q, borrow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SIZE-1:0]   r_q, r_d;
  logic              bo_q, bo_d;
  logic              z_q, z_d;
  logic              v_q, v_d;

  logic              fs_x, fs_y, fs_d, fs_bout;
  logic [SIZE-1:0]   res_next;

  assign fs_x = a_sh_q[0];
  assign fs_y = b_sh_q[0];

  sub_serial_8_full_subtractor u_full_subtractor (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result fills from the top so that after SIZE steps bit 0 is the LSB.
  assign res_next = {fs_d, res_sh_q[SIZE-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    bo_d     = bo_q;
    z_d      = z_q;
    v_d      = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          r_d     = res_next;
          bo_d    = fs_bout;
          z_d     = (res_next == '0);
          // On the last step x/y are the original sign bits and fs_d is r's MSB.
          v_d     = (fs_x ^ fs_y) & (fs_d ^ fs_x);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
      bo_q     <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      r_q      <= r_d;
      bo_q     <= bo_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign bo   = bo_q;
  assign z    = z_q;
  assign v    = v_q;

endmodule
